// File: rtl/fv_enc_pkg.sv
// Shared FV-encryption definitions: default modulus, coefficient type and
// the single-step modular reduction used after a coefficient add.
package fv_enc_pkg;

  localparam int QW_DEFAULT = 64;
  localparam logic [QW_DEFAULT-1:0] Q_DEFAULT = 64'hFFFF_FFFF_0000_0001;

  typedef logic [QW_DEFAULT-1:0] coef_t;
  typedef logic [QW_DEFAULT:0]   sum_t;

  // Both addends lie in [0, q), so the sum is below 2q and one conditional
  // subtract brings it back into range.
  function automatic coef_t add_mod_reduce(input sum_t sum, input sum_t q);
    return (sum >= q) ? coef_t'(sum - q) : coef_t'(sum);
  endfunction

endpackage

// File: rtl/axis_if.sv
// Valid/ready coefficient stream with an end-of-polynomial marker.
interface axis_if #(
  parameter int W = 64
) ();

  logic [W-1:0] data;
  logic         vld;
  logic         last;
  logic         rdy;

  modport in  (input  data, vld, last, output rdy);
  modport out (output data, vld, last, input  rdy);

endinterface

// File: rtl/axis_join2.sv
// Two-input stream join: a beat is taken from both streams together or from
// neither, and only when the downstream stage can advance.
module axis_join2 (
  input  logic a_vld,
  input  logic b_vld,
  input  logic adv,
  output logic a_rdy,
  output logic b_rdy,
  output logic pair_vld,
  output logic join_go
);

  // Each side is ready only if its partner has a beat waiting.
  assign pair_vld = a_vld & b_vld;
  assign a_rdy    = adv & b_vld;
  assign b_rdy    = adv & a_vld;
  assign join_go  = adv & pair_vld;

endmodule

// File: rtl/poly_add_mod.sv
// Coefficient-wise (z + e) mod Q over two joined streams, two-stage pipeline,
// with a sticky framing-error flag.
// Optional macro POLY_ADD_MOD_LEN_CHK_EN adds a per-polynomial beat counter
// that also flags polynomials whose length is not N.
module poly_add_mod
  import fv_enc_pkg::*;
#(
  parameter int             N  = 16,
  parameter int             QW = 64,
  parameter logic [QW-1:0]  Q  = QW'(Q_DEFAULT)
) (
  input  logic clk,
  input  logic s_rst_n,
  axis_if.in   z,
  axis_if.in   e,
  axis_if.out  c,
  output logic err
);

  logic          adv;
  logic          pair_vld;
  logic          join_go;
  logic          s1_vld;
  logic          s1_last;
  logic [QW:0]   s1_sum;
  logic          c_vld_q;
  logic          c_last_q;
  logic [QW-1:0] c_data_q;
  logic [QW-1:0] c_data_d;
  logic          len_err;

  // The whole pipeline moves together whenever the output slot is free.
  assign adv = !c_vld_q | c.rdy;

  axis_join2 u_join (
    .a_vld    (z.vld),
    .b_vld    (e.vld),
    .adv      (adv),
    .a_rdy    (z.rdy),
    .b_rdy    (e.rdy),
    .pair_vld (pair_vld),
    .join_go  (join_go)
  );

  // Stage 1: capture the full-width sum of the joined pair.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      // NOTE: datapath registers are reset only to give a clean, defined
      // value; correctness relies on the valid bits alone.
      s1_sum  <= '0;
    end else begin
      if (adv) s1_vld <= pair_vld;
      if (join_go) begin
        s1_sum  <= {1'b0, z.data} + {1'b0, e.data};
        s1_last <= z.last;
      end
    end
  end

  // Reduce the stage-1 sum into [0, Q).
  always_comb begin
    c_data_d = QW'(add_mod_reduce(sum_t'(s1_sum), sum_t'({1'b0, Q})));
  end

  // Stage 2: output register, held stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      c_vld_q  <= 1'b0;
      c_last_q <= 1'b0;
      c_data_q <= '0;
    end else if (adv) begin
      c_vld_q  <= s1_vld;
      c_last_q <= s1_last;
      c_data_q <= c_data_d;
    end
  end

  assign c.vld  = c_vld_q;
  assign c.last = c_last_q;
  assign c.data = c_data_q;

`ifdef POLY_ADD_MOD_LEN_CHK_EN
  localparam int              CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(N - 1);

  logic [CW-1:0] cnt;

  // A polynomial is malformed if last arrives early, or fails to arrive on
  // the N-th beat.
  // NOTE: always_comb must assign every output on every path to avoid an
  // inferred latch; here a single full expression covers both cases.
  always_comb begin
    len_err = z.last ? (cnt != LAST_IDX) : (cnt == LAST_IDX);
  end

  // Beat index within the current polynomial; wraps on last or on beat N.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      cnt <= '0;
    end else if (join_go) begin
      cnt <= (z.last || cnt == LAST_IDX) ? '0 : cnt + CW'(1);
    end
  end
`else
  assign len_err = 1'b0;
`endif

  // Sticky framing error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      err <= 1'b0;
    end else if (join_go && ((z.last != e.last) || len_err)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_poly_add_mod.sv
// Self-checking bench for poly_add_mod (QW=5, Q=17, N=4). Stream drivers and
// a negedge monitor run alongside one directed-step initial block; expected
// results come from a queue of (z + e) % Q values recorded at each join.
// Build with or without POLY_ADD_MOD_LEN_CHK_EN; expectations follow it.
module tb_poly_add_mod;

  localparam int            N  = 4;
  localparam int            QW = 5;
  localparam logic [QW-1:0] Q  = 5'd17;

  logic clk = 1'b0;
  logic s_rst_n;
  logic err;

  always #5 clk = ~clk;

  axis_if #(.W(QW)) z_if ();
  axis_if #(.W(QW)) e_if ();
  axis_if #(.W(QW)) c_if ();

  poly_add_mod #(.N(N), .QW(QW), .Q(Q)) dut (
    .clk     (clk),
    .s_rst_n (s_rst_n),
    .z       (z_if),
    .e       (e_if),
    .c       (c_if),
    .err     (err)
  );

  typedef struct { logic [QW-1:0] data; logic last; } beat_t;
  typedef struct { int data; logic last; int cyc; } exp_t;

  beat_t zq[$];
  beat_t eq[$];
  exp_t  xq[$];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   joins = 0;
  bit   z_hold = 0, e_hold = 0;
  int   z_gap = 0, e_gap = 0;
  int   c_mode = 0;
  bit   lat_chk = 0;
  logic m_err = 1'b0;
  int   m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // z stream driver: presents queued beats, holds each until accepted.
  initial begin : drv_z
    beat_t b;
    bit    fire;
    z_if.vld = 1'b0; z_if.data = '0; z_if.last = 1'b0;
    forever begin
      @(negedge clk);
      fire = z_if.vld & z_if.rdy;
      @(posedge clk);
      #2;
      if (z_hold) z_if.vld = 1'b0;
      else if (fire || !z_if.vld) begin
        if (zq.size() > 0 && $urandom_range(99) >= z_gap) begin
          b = zq.pop_front();
          z_if.data = b.data; z_if.last = b.last; z_if.vld = 1'b1;
        end else z_if.vld = 1'b0;
      end
    end
  end

  // e stream driver, same protocol as z.
  initial begin : drv_e
    beat_t b;
    bit    fire;
    e_if.vld = 1'b0; e_if.data = '0; e_if.last = 1'b0;
    forever begin
      @(negedge clk);
      fire = e_if.vld & e_if.rdy;
      @(posedge clk);
      #2;
      if (e_hold) e_if.vld = 1'b0;
      else if (fire || !e_if.vld) begin
        if (eq.size() > 0 && $urandom_range(99) >= e_gap) begin
          b = eq.pop_front();
          e_if.data = b.data; e_if.last = b.last; e_if.vld = 1'b1;
        end else e_if.vld = 1'b0;
      end
    end
  end

  // Consumer ready: 0 = always ready, 1 = stalled, 2 = random.
  initial begin : drv_c
    c_if.rdy = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (c_mode)
        0:       c_if.rdy = 1'b1;
        1:       c_if.rdy = 1'b0;
        default: c_if.rdy = 1'($urandom_range(1));
      endcase
    end
  end

  // Monitor: handshake rules, stall stability, output ordering, err model.
  initial begin : monitor
    bit            prev_stall = 0;
    logic [QW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    bit            zf, ef;
    exp_t          x;
    forever begin
      @(negedge clk);
      if (!s_rst_n) begin
        xq.delete();
        m_err = 1'b0;
        m_cnt = 0;
        prev_stall = 0;
      end else begin
        check("err_flag", err, m_err);
        check("z_rdy", z_if.rdy, e_if.vld & (!c_if.vld | c_if.rdy));
        check("e_rdy", e_if.rdy, z_if.vld & (!c_if.vld | c_if.rdy));
        if (prev_stall) begin
          check("hold_vld", c_if.vld, 1);
          check("hold_data", c_if.data, prev_data);
          check("hold_last", c_if.last, prev_last);
        end
        if (c_if.vld && c_if.rdy) begin
          if (xq.size() == 0) check("c_extra_beat", 1, 0);
          else begin
            x = xq.pop_front();
            check("c_data", c_if.data, x.data);
            check("c_last", c_if.last, x.last);
            if (lat_chk) check("latency", cyc - x.cyc, 2);
          end
        end
        zf = z_if.vld & z_if.rdy;
        ef = e_if.vld & e_if.rdy;
        check("join_pair", ef, zf);
        if (zf && ef) begin
          x.data = (int'(z_if.data) + int'(e_if.data)) % int'(Q);
          x.last = z_if.last;
          x.cyc  = cyc;
          xq.push_back(x);
          joins++;
          if (z_if.last != e_if.last) m_err = 1'b1;
`ifdef POLY_ADD_MOD_LEN_CHK_EN
          if (z_if.last) begin
            if (m_cnt != N - 1) m_err = 1'b1;
            m_cnt = 0;
          end else if (m_cnt == N - 1) begin
            m_err = 1'b1;
            m_cnt = 0;
          end else m_cnt++;
`endif
        end
        prev_stall = c_if.vld & !c_if.rdy;
        prev_data  = c_if.data;
        prev_last  = c_if.last;
      end
    end
  end

  task automatic push(input int zd, input int zl, input int ed, input int el);
    beat_t b;
    b.data = zd[QW-1:0]; b.last = zl[0]; zq.push_back(b);
    b.data = ed[QW-1:0]; b.last = el[0]; eq.push_back(b);
  endtask

  task automatic push_rand_poly(input int n);
    for (int i = 0; i < n; i++)
      push($urandom_range(int'(Q) - 1), int'(i == n - 1),
           $urandom_range(int'(Q) - 1), int'(i == n - 1));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    bit idle = 0;
    while (!idle && n < budget) begin
      @(negedge clk);
      idle = zq.size() == 0 && eq.size() == 0 && !z_if.vld && !e_if.vld &&
             xq.size() == 0 && !c_if.vld;
      n++;
    end
    check(tag, idle, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_rst_n = 1'b0;
    @(posedge clk);
    #1;
    s_rst_n = 1'b1;
    @(negedge clk);
    check("rst_err", err, 0);
    check("rst_c_vld", c_if.vld, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int j0;
    int n;
    s_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_c_vld", c_if.vld, 0);
    check("rst_c_last", c_if.last, 0);
    check("rst_c_data", c_if.data, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1;
    s_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reduction corners: 10+9 -> 2, 16+0 -> 16, 16+1 -> 0, exact 2-cycle latency.
    lat_chk = 1;
    push(10, 0, 9, 0);
    push(16, 0, 0, 0);
    push(16, 0, 1, 0);
    push(3, 1, 5, 1);
    wait_idle("drain_reduce", 40);

    // Full throughput: one result per cycle, last on 4th beat only.
    push_rand_poly(N);
    wait_idle("drain_thru", 40);
    check("thru_err", err, 0);
    lat_chk = 0;

    // Skew on e, then a 5-cycle output stall mid-polynomial.
    e_hold = 1;
    j0 = joins;
    push_rand_poly(N);
    repeat (3) @(posedge clk);
    #1;
    check("skew_no_join", joins, j0);
    e_hold = 0;
    repeat (2) @(posedge clk);
    #1;
    c_mode = 1;
    repeat (5) @(posedge clk);
    #1;
    c_mode = 0;
    wait_idle("drain_skew", 60);

    // Last mismatch on beat 4, then a clean polynomial: err stays set.
    push(1, 0, 2, 0);
    push(4, 0, 7, 0);
    push(15, 0, 15, 0);
    push(8, 1, 9, 0);
    wait_idle("drain_mismatch", 40);
    check("mismatch_err", err, 1);
    push_rand_poly(N);
    wait_idle("drain_after_mm", 40);
    check("mismatch_sticky", err, 1);
    do_reset();

    // Short polynomial: last on beat 3 of both streams.
    push_rand_poly(3);
    wait_idle("drain_short", 40);
`ifdef POLY_ADD_MOD_LEN_CHK_EN
    check("short_err", err, 1);
`else
    check("short_err", err, 0);
`endif
    do_reset();

    // Reset with two beats in flight behind a stalled output.
    c_mode = 1;
    j0 = joins;
    push_rand_poly(N);
    n = 0;
    while (joins < j0 + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("inflight_joins", joins - j0, 2);
    @(posedge clk);
    #1;
    z_hold = 1; e_hold = 1;
    zq.delete(); eq.delete();
    s_rst_n = 1'b0;
    @(posedge clk);
    #1;
    s_rst_n = 1'b1;
    z_hold = 0; e_hold = 0;
    c_mode = 0;
    @(negedge clk);
    check("midrst_c_vld", c_if.vld, 0);
    @(posedge clk);
    #1;
    push_rand_poly(N);
    wait_idle("drain_post_rst", 40);
    check("post_rst_err", err, 0);

    // Random traffic: gaps on both inputs, random consumer stalls.
    c_mode = 2; z_gap = 30; e_gap = 30;
    for (int p = 0; p < 8; p++) push_rand_poly(N);
    n = 0;
    while ((zq.size() > 0 || eq.size() > 0) && n < 800) begin
      @(posedge clk);
      n++;
    end
    c_mode = 0; z_gap = 0; e_gap = 0;
    wait_idle("drain_random", 200);
    check("random_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
